parking_access_controller: RTL
==============================

PARKING_ACCESS_CONTROLLER -- requirements
Module: parking_access_controller

Interface
REQ-001 The block SHALL expose parameter PASS, default 5'b10011, the access code compared against keypad entries.
REQ-002 The block SHALL expose parameter MAX_TRIES, default 3, the number of wrong codes allowed before lockout (range 1..3).
REQ-003 The block SHALL expose parameter LOCK_CYCLES, default 16, the lockout duration in clocks.
REQ-004 The block SHALL expose parameter GATE_HOLD, default 8, the gate-open duration in clocks.
REQ-005 The block SHALL expose parameter TIMEOUT_CYCLES, default 64, the idle limit while waiting for keypad input.
REQ-006 Ports SHALL be exactly:
 clk  in  1  single clock, all state on rising edge
 rst_n  in  1  reset, synchronous, active-low
 entry_sensor  in  1  level, car present at entry lane
 exit_sensor  in  1  level, car present at exit lane
 pw_valid  in  1  one-cycle strobe, pw_data valid
 pw_data  in  5  keypad code
 pos_valid  in  1  one-cycle strobe, pos_data valid
 pos_data  in  4  slot number, legal 1..10
 occupied  in  10  slot occupancy map from parking core, bit n-1 = slot n
 req_valid  out  1  one-cycle pulse presenting a request to the parking core
 req_entry  out  1  request is an entry
 req_exit  out  1  request is an exit
 req_password  out  5  code forwarded to core
 req_position  out  4  slot forwarded to core
 gate_open  out  1  barrier drive
 locked  out  1  lockout active
 pw_error  out  1  one-cycle pulse, wrong code
 pos_error  out  1  one-cycle pulse, illegal slot
 tries_left  out  2  remaining wrong-code allowance

Function
REQ-007 The FSM SHALL have states IDLE, PW_WAIT, POS_WAIT, ISSUE, GRANT, LOCKOUT.
REQ-008 IDLE SHALL register both sensors and detect rising edges; a rising edge moves to PW_WAIT next cycle and latches direction; sensor edges outside IDLE are ignored.
REQ-009 Simultaneous entry and exit edges in IDLE SHALL latch exit (exit frees space; entry edge is discarded).
REQ-010 PW_WAIT on pw_valid with pw_data==PASS SHALL move to POS_WAIT and reload tries_left to MAX_TRIES.
REQ-011 PW_WAIT on pw_valid with wrong code SHALL pulse pw_error and decrement tries_left; when tries_left would reach 0 the FSM SHALL enter LOCKOUT instead.
REQ-012 POS_WAIT on pos_valid SHALL accept pos_data only if 1..10 and occupied[pos_data-1] is 0 for entry or 1 for exit; otherwise pulse pos_error and stay in POS_WAIT.
REQ-013 Accepted slot SHALL move to ISSUE; ISSUE SHALL assert req_valid exactly one cycle with req_password=PASS, req_position=latched slot, exactly one of req_entry/req_exit high, then go to GRANT.
REQ-014 req_password, req_position, req_entry, req_exit SHALL hold their values from ISSUE until the next ISSUE and be zero only after reset.
REQ-015 GRANT SHALL hold gate_open=1 for exactly GATE_HOLD cycles, then return to IDLE with gate_open=0.
REQ-016 LOCKOUT SHALL hold locked=1 for exactly LOCK_CYCLES cycles, ignore all inputs, then return to IDLE with tries_left=MAX_TRIES.
REQ-017 pw_valid outside PW_WAIT and pos_valid outside POS_WAIT SHALL be ignored with no error pulse.
REQ-018 tries_left SHALL be restored only by success, lockout expiry or reset.

Reset
REQ-019 With rst_n low at a clock edge: state=IDLE, tries_left=MAX_TRIES, all other outputs 0, counters and sensor history 0; reset mid-GRANT or mid-LOCKOUT SHALL drop gate_open/locked on the following cycle.

Configuration
REQ-020 Macro ACCESS_TIMEOUT_EN defined: PW_WAIT or POS_WAIT with no strobe for TIMEOUT_CYCLES consecutive cycles SHALL return to IDLE with no request and tries_left unchanged; each accepted or rejected strobe restarts the count.
REQ-021 Macro ACCESS_TIMEOUT_EN undefined: PW_WAIT and POS_WAIT SHALL wait indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-022 entry_sensor rise, pw 10011, pos 3, occupied=0 -> one req_valid, req_entry=1, req_position=3, gate_open high 8 cycles.
REQ-023 exit_sensor rise, pw 10011, pos 7 with occupied[6]=0 -> pos_error pulse, stay POS_WAIT; pos 7 after occupied[6]=1 -> req_exit=1.
REQ-024 three wrong codes (00000) -> three pw_error pulses, tries_left 2,1 then locked high 16 cycles, then tries_left=3.
REQ-025 entry and exit rise same cycle -> latched exit; pos 0 and pos 11 -> pos_error each.
REQ-026 ACCESS_TIMEOUT_EN: entry rise, no input 64 cycles -> IDLE, no req_valid; rst_n low during GRANT -> gate_open 0 next cycle.

Source files
------------

// File: rtl/parking_access_controller.sv
// Parking access controller: sensor edge -> keypad code -> slot check -> one core request -> timed gate.
// Latency: sensor edge to PW_WAIT 1 clk; accepted slot to req_valid 1 clk; gate_open opens 1 clk after req_valid.
// No backpressure: strobes are one-cycle and are consumed or ignored in the cycle they arrive.
//
// Ports:
//   clk, rst_n (synchronous, active-low)
//   entry_sensor, exit_sensor        car-present levels, rising edge starts a session (IDLE only)
//   pw_valid/pw_data[4:0]            keypad code strobe
//   pos_valid/pos_data[3:0]          slot number strobe, legal 1..10
//   occupied[9:0]                    occupancy map, bit n-1 = slot n
//   req_valid, req_entry, req_exit,
//   req_password[4:0], req_position[3:0]  request to parking core (fields hold until next request)
//   gate_open, locked                barrier drive, lockout indicator
//   pw_error, pos_error              one-cycle error pulses
//   tries_left[1:0]                  remaining wrong-code allowance
//
// Optional feature: define ACCESS_TIMEOUT_EN to abandon PW_WAIT/POS_WAIT after
// TIMEOUT_CYCLES strobe-free cycles. Without it those states wait indefinitely.
module parking_access_controller #(
  parameter logic [4:0] PASS           = 5'b10011,
  parameter int         MAX_TRIES      = 3,
  parameter int         LOCK_CYCLES    = 16,
  parameter int         GATE_HOLD      = 8,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_sensor,
  input  logic       exit_sensor,
  input  logic       pw_valid,
  input  logic [4:0] pw_data,
  input  logic       pos_valid,
  input  logic [3:0] pos_data,
  input  logic [9:0] occupied,
  output logic       req_valid,
  output logic       req_entry,
  output logic       req_exit,
  output logic [4:0] req_password,
  output logic [3:0] req_position,
  output logic       gate_open,
  output logic       locked,
  output logic       pw_error,
  output logic       pos_error,
  output logic [1:0] tries_left
);

  // One counter width covers gate hold, lockout and the idle timeout.
  localparam int CNT_MAX_A = (LOCK_CYCLES > GATE_HOLD) ? LOCK_CYCLES : GATE_HOLD;
  localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [1:0]    TRIES_INIT = MAX_TRIES[1:0];
  localparam logic [CW-1:0] GATE_LOAD  = CW'(GATE_HOLD - 1);
  localparam logic [CW-1:0] LOCK_LOAD  = CW'(LOCK_CYCLES - 1);
`ifdef ACCESS_TIMEOUT_EN
  localparam logic [CW-1:0] IDLE_LAST  = CW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    PW_WAIT,
    POS_WAIT,
    ISSUE,
    GRANT,
    LOCKOUT
  } state_t;

  state_t        state;
  logic          entry_q;
  logic          exit_q;
  logic          dir_exit;   // latched session direction, 1 = exit
  logic [CW-1:0] cnt;        // gate / lockout countdown
`ifdef ACCESS_TIMEOUT_EN
  logic [CW-1:0] idle_cnt;   // strobe-free cycles spent in a wait state
`endif

  logic        entry_rise;
  logic        exit_rise;
  logic [15:0] occ_ext;
  logic [3:0]  pos_idx;
  logic        pos_in_range;
  logic        slot_bit;
  logic        pos_ok;

  assign entry_rise = entry_sensor & ~entry_q;
  assign exit_rise  = exit_sensor & ~exit_q;

  // Zero-extend the map so an out-of-range slot never indexes past the vector;
  // the range check below rejects those slots anyway.
  assign occ_ext      = {6'd0, occupied};
  assign pos_idx      = pos_data - 4'd1;
  assign pos_in_range = (pos_data >= 4'd1) && (pos_data <= 4'd10);
  assign slot_bit     = occ_ext[pos_idx];
  // Entry needs a free slot, exit needs an occupied one.
  assign pos_ok       = pos_in_range && (slot_bit == dir_exit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      entry_q      <= 1'b0;
      exit_q       <= 1'b0;
      dir_exit     <= 1'b0;
      cnt          <= '0;
`ifdef ACCESS_TIMEOUT_EN
      idle_cnt     <= '0;
`endif
      req_valid    <= 1'b0;
      req_entry    <= 1'b0;
      req_exit     <= 1'b0;
      req_password <= 5'd0;
      req_position <= 4'd0;
      gate_open    <= 1'b0;
      locked       <= 1'b0;
      pw_error     <= 1'b0;
      pos_error    <= 1'b0;
      tries_left   <= TRIES_INIT;
    end else begin
      // Sensor history tracks every cycle so an edge that happened while busy
      // is simply absorbed rather than replayed on return to IDLE.
      entry_q   <= entry_sensor;
      exit_q    <= exit_sensor;
      req_valid <= 1'b0;
      pw_error  <= 1'b0;
      pos_error <= 1'b0;

      case (state)
        IDLE: begin
`ifdef ACCESS_TIMEOUT_EN
          idle_cnt <= '0;
`endif
          // Exit wins a tie: it frees space.
          if (exit_rise) begin
            dir_exit <= 1'b1;
            state    <= PW_WAIT;
          end else if (entry_rise) begin
            dir_exit <= 1'b0;
            state    <= PW_WAIT;
          end
        end

        PW_WAIT: begin
          if (pw_valid) begin
`ifdef ACCESS_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (pw_data == PASS) begin
              tries_left <= TRIES_INIT;
              state      <= POS_WAIT;
            end else begin
              pw_error <= 1'b1;
              if (tries_left <= 2'd1) begin
                tries_left <= 2'd0;
                locked     <= 1'b1;
                cnt        <= LOCK_LOAD;
                state      <= LOCKOUT;
              end else begin
                tries_left <= tries_left - 2'd1;
              end
            end
          end
`ifdef ACCESS_TIMEOUT_EN
          else if (idle_cnt == IDLE_LAST) begin
            state <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end

        POS_WAIT: begin
          if (pos_valid) begin
`ifdef ACCESS_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (pos_ok) begin
              // Request fields load here so they are valid during ISSUE and hold afterwards.
              req_valid    <= 1'b1;
              req_entry    <= ~dir_exit;
              req_exit     <= dir_exit;
              req_password <= PASS;
              req_position <= pos_data;
              state        <= ISSUE;
            end else begin
              pos_error <= 1'b1;
            end
          end
`ifdef ACCESS_TIMEOUT_EN
          else if (idle_cnt == IDLE_LAST) begin
            state <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end

        ISSUE: begin
          gate_open <= 1'b1;
          cnt       <= GATE_LOAD;
          state     <= GRANT;
        end

        GRANT: begin
          if (cnt == '0) begin
            gate_open <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        LOCKOUT: begin
          if (cnt == '0) begin
            locked     <= 1'b0;
            tries_left <= TRIES_INIT;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
